gmii_tx_framer: RTL and testbench
=================================

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter IFG_BYTES, default 12, is the idle byte-times inserted after every frame; legal range 1..255.
REQ-002 Parameter PRE_BYTES, default 7, is the count of 0x55 preamble bytes before the SFD; legal range 1..15.
REQ-003 i_TxClk  in  1  sole clock; all logic on its rising edge.
REQ-004 i_Reset  in  1  asynchronous, active-high reset.
REQ-005 i2_Speed  in  2  2'b10 selects 1000 Mb/s byte mode; any other value selects 10/100 nibble mode.
REQ-006 i8_Data  in  8  payload byte.
REQ-007 i_Valid  in  1  i8_Data, i_Last and i_Err are valid.
REQ-008 i_Last  in  1  the current byte is the final payload byte.
REQ-009 i_Err  in  1  the current byte is transmitted with TxER asserted.
REQ-010 o_Ready  out  1  the framer accepts the byte on this edge if i_Valid is high.
REQ-011 o8_TxD  out  8  GMII/MII transmit data; bits 7:4 are 0 in nibble mode.
REQ-012 o_TxEN  out  1  transmit enable.
REQ-013 o_TxER  out  1  transmit error.
REQ-014 o_Busy  out  1  the state is anything other than IDLE.

Function
REQ-015 o8_TxD, o_TxEN, o_TxER and o_Busy shall be registered; o_Ready shall be a decode of the registered state only.
REQ-016 A byte shall be accepted on a rising edge where i_Valid and o_Ready are both high.
REQ-017 The FSM states shall be IDLE, PRE, SFD, DATA, DROP and IFG.
REQ-018 In IDLE, o_Ready shall be 0, o_TxEN 0, o_TxER 0 and o8_TxD 0x00.
REQ-019 IDLE -> PRE on the first edge with i_Valid=1; the mode shall be latched from i2_Speed on that edge and held until the next return to IDLE.
REQ-020 Byte mode: PRE shall drive 0x55 with TxEN=1 for PRE_BYTES cycles, then SFD shall drive 0xD5 for 1 cycle.
REQ-021 Nibble mode: PRE shall drive 0x05 for 2*PRE_BYTES cycles; SFD shall then drive 0x05 for 1 cycle followed by 0x0D for 1 cycle.
REQ-022 o_Ready shall be 1 during the last SFD cycle, so the first payload byte appears on o8_TxD in the cycle immediately after the SFD.
REQ-023 Byte mode DATA: each accepted byte shall be driven for 1 cycle with TxEN=1 and TxER=i_Err; o_Ready shall be 1 in every DATA cycle except the cycle that drives the byte accepted with i_Last=1.
REQ-024 Nibble mode DATA: each byte shall be driven low nibble first, then high nibble, 1 cycle each, with TxER=i_Err on both cycles.
REQ-025 Nibble mode DATA: o_Ready shall be 1 only during the high-nibble cycle, and 0 during the high-nibble cycle of the i_Last byte.
REQ-026 After the i_Last byte has been fully output, the next cycle shall drive TxEN=0 and the FSM shall enter IFG.
REQ-027 IFG shall hold TxEN=0, TxD=0 and o_Ready=0 for IFG_BYTES byte-times: IFG_BYTES cycles in byte mode, 2*IFG_BYTES cycles in nibble mode; IFG -> IDLE when the count expires.
REQ-028 Underrun: if o_Ready=1 in DATA and i_Valid=0, the next byte-time shall drive TxEN=1, TxER=1, TxD=0x00, then TxEN=0.
REQ-029 After an underrun the FSM shall enter DROP.
REQ-030 DROP shall hold o_Ready=1, discard accepted bytes, and pass to IFG on the edge that accepts i_Last=1.
REQ-031 Frames shall be unbounded in length; the internal counters shall be at most 8 bits and shall saturate, not wrap, at their terminal count.
REQ-032 A change of i2_Speed during a frame shall have no effect until IDLE.

Reset
REQ-033 While i_Reset=1, the FSM shall be in IDLE, all counters 0, o8_TxD=0x00, o_TxEN=0, o_TxER=0, o_Ready=0 and o_Busy=0, asynchronously.
REQ-034 Reset asserted mid-frame shall abort the frame immediately with no TxER; the first frame after release shall begin with a full preamble.

Verification
REQ-035 Byte mode, 3-byte frame AA BB CC (Last on CC) -> TxD 55x7, D5, AA, BB, CC with TxEN=1, then TxEN=0 for 12 cycles; o_Busy low on the 13th idle cycle.
REQ-036 Nibble mode, 1-byte frame 0xA5 -> TxD 5x15, D, 5, A with TxEN=1, then TxEN=0 for 24 cycles.
REQ-037 Byte mode, 4-byte frame with i_Valid dropped before byte 3 -> bytes 1 and 2 on TxD, one cycle TxEN=1/TxER=1/TxD=00, then TxEN=0; bytes up to i_Last are consumed and never output; IFG follows.
REQ-038 Byte mode, i_Err=1 on byte 2 of 3 -> TxER=1 on exactly that data cycle, and 0 on all others.
REQ-039 i_Reset pulsed during byte 5 of a 10-byte frame -> outputs reach 0 within the pulse; after release, the next frame starts with 55x7 D5.
REQ-040 Back-to-back frames with i_Valid held high -> exactly IFG_BYTES byte-times of TxEN=0 between the last byte of frame 1 and the first preamble byte of frame 2.

Source files
------------

// File: rtl/gmii_tx_framer_if.sv
// gmii_tx_framer_if
//   Payload stream in, GMII/MII transmit symbols out.
//   master : payload source / line observer (drives i*, reads o*)
//   slave  : the framer (reads i*, drives o*)
//   i2_Speed  2'b10 = 1000 Mb/s byte mode, else 10/100 nibble mode
//   i8_Data / i_Valid / i_Last / i_Err  payload byte + qualifiers
//   o_Ready   byte accepted on an edge with i_Valid && o_Ready
//   o8_TxD / o_TxEN / o_TxER  line symbols; o_Busy = not idle
interface gmii_tx_framer_if;
  logic [1:0] i2_Speed;
  logic [7:0] i8_Data;
  logic       i_Valid;
  logic       i_Last;
  logic       i_Err;
  logic       o_Ready;
  logic [7:0] o8_TxD;
  logic       o_TxEN;
  logic       o_TxER;
  logic       o_Busy;

  modport master (
    output i2_Speed, i8_Data, i_Valid, i_Last, i_Err,
    input  o_Ready, o8_TxD, o_TxEN, o_TxER, o_Busy
  );

  modport slave (
    input  i2_Speed, i8_Data, i_Valid, i_Last, i_Err,
    output o_Ready, o8_TxD, o_TxEN, o_TxER, o_Busy
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer
//   Wraps a payload byte stream into a GMII (byte) or MII (nibble) frame:
//   preamble, SFD, payload, inter-frame gap. Underrun mid-frame emits one
//   byte-time of TxER and discards the rest of the frame up to i_Last.
//   i_TxClk  : sole clock, rising edge
//   i_Reset  : asynchronous, active-high
//   io_Gmii  : payload stream + line outputs (slave modport)
//   IFG_BYTES: idle byte-times after each frame (1..255)
//   PRE_BYTES: preamble bytes before SFD (1..15)
module gmii_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int PRE_BYTES = 7
) (
  input  logic             i_TxClk,
  input  logic             i_Reset,
  gmii_tx_framer_if.slave  io_Gmii
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DROP, IFG} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRE_BYTES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  state_t     r_State;
  logic       r_Nib;      // mode latched at frame start
  logic       r_Ph;       // nibble phase: 0 = first/low, 1 = second/high
  logic       r_IsLast;
  logic       r_ByteErr;
  logic [3:0] r4_Hi;      // high nibble waiting to go out
  logic [7:0] r8_Cnt;     // byte-time counter, saturating
  logic [7:0] r8_TxD;
  logic       r_TxEN;
  logic       r_TxER;
  logic       r_Busy;

  logic       w_Tick;
  logic       w_Ready;
  logic       w_Take;
  logic       w_Start;
  logic       w_NibIn;
  logic [7:0] w8_CntInc;

  // A byte-time ends on every cycle in byte mode, every second in nibble mode.
  assign w_Tick    = ~r_Nib | r_Ph;
  assign w_NibIn   = (io_Gmii.i2_Speed != 2'b10);
  assign w8_CntInc = (r8_Cnt == 8'hFF) ? r8_Cnt : r8_Cnt + 8'd1;

  // Ready on the final cycle of SFD and of each non-final payload byte, and
  // throughout DROP; purely a decode of registered state.
  assign w_Take  = ((r_State == SFD) || (r_State == DATA && !r_IsLast)) && w_Tick;
  assign w_Ready = w_Take || (r_State == DROP);

  // A frame waiting at IFG expiry starts straight away so the gap between
  // back-to-back frames is exactly IFG_BYTES byte-times.
  assign w_Start = io_Gmii.i_Valid &&
                   ((r_State == IDLE) ||
                    (r_State == IFG && w_Tick && r8_Cnt == IFG_LAST));

  always_ff @(posedge i_TxClk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State   <= IDLE;
      r_Nib     <= 1'b0;
      r_Ph      <= 1'b0;
      r_IsLast  <= 1'b0;
      r_ByteErr <= 1'b0;
      r4_Hi     <= 4'h0;
      r8_Cnt    <= 8'h00;
      r8_TxD    <= 8'h00;
      r_TxEN    <= 1'b0;
      r_TxER    <= 1'b0;
      r_Busy    <= 1'b0;
    end else if (w_Start) begin
      r_State  <= PRE;
      r_Nib    <= w_NibIn;
      r_Ph     <= 1'b0;
      r_IsLast <= 1'b0;
      r8_Cnt   <= 8'h00;
      r8_TxD   <= w_NibIn ? 8'h05 : 8'h55;
      r_TxEN   <= 1'b1;
      r_TxER   <= 1'b0;
      r_Busy   <= 1'b1;
    end else if (w_Take) begin
      r_Ph <= 1'b0;
      if (io_Gmii.i_Valid) begin
        r_State   <= DATA;
        r_IsLast  <= io_Gmii.i_Last;
        r_ByteErr <= io_Gmii.i_Err;
        r4_Hi     <= io_Gmii.i8_Data[7:4];
        r8_TxD    <= r_Nib ? {4'h0, io_Gmii.i8_Data[3:0]} : io_Gmii.i8_Data;
        r_TxEN    <= 1'b1;
        r_TxER    <= io_Gmii.i_Err;
      end else begin
        // underrun: poison the frame with an error byte-time
        r_State <= DROP;
        r8_Cnt  <= 8'h00;
        r8_TxD  <= 8'h00;
        r_TxEN  <= 1'b1;
        r_TxER  <= 1'b1;
      end
    end else begin
      case (r_State)
        PRE: begin
          r_Ph <= r_Nib & ~r_Ph;
          if (w_Tick) begin
            if (r8_Cnt == PRE_LAST) begin
              r_State <= SFD;
              r8_Cnt  <= 8'h00;
              r8_TxD  <= r_Nib ? 8'h05 : 8'hD5;
            end else begin
              r8_Cnt <= w8_CntInc;
            end
          end
        end
        SFD: begin
          // only reached on the first nibble of SFD
          r_Ph   <= 1'b1;
          r8_TxD <= 8'h0D;
        end
        DATA: begin
          if (!w_Tick) begin
            r_Ph   <= 1'b1;
            r8_TxD <= {4'h0, r4_Hi};
            r_TxER <= r_ByteErr;
          end else begin
            // final byte fully sent
            r_State <= IFG;
            r_Ph    <= 1'b0;
            r8_Cnt  <= 8'h00;
            r8_TxD  <= 8'h00;
            r_TxEN  <= 1'b0;
            r_TxER  <= 1'b0;
          end
        end
        DROP: begin
          r8_Cnt <= w8_CntInc;
          if (io_Gmii.i_Valid && io_Gmii.i_Last) begin
            r_State <= IFG;
            r_Ph    <= 1'b0;
            r8_Cnt  <= 8'h00;
            r_TxEN  <= 1'b0;
            r_TxER  <= 1'b0;
          end else begin
            // error byte-time is two cycles in nibble mode
            r_TxEN <= r_Nib && (r8_Cnt == 8'h00);
            r_TxER <= r_Nib && (r8_Cnt == 8'h00);
          end
        end
        IFG: begin
          r_Ph <= r_Nib & ~r_Ph;
          if (w_Tick) begin
            if (r8_Cnt == IFG_LAST) begin
              r_State <= IDLE;
              r_Busy  <= 1'b0;
              r8_Cnt  <= 8'h00;
            end else begin
              r8_Cnt <= w8_CntInc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_Gmii.o_Ready = w_Ready;
  assign io_Gmii.o8_TxD  = r8_TxD;
  assign io_Gmii.o_TxEN  = r_TxEN;
  assign io_Gmii.o_TxER  = r_TxER;
  assign io_Gmii.o_Busy  = r_Busy;

endmodule

// File: tb/tb_gmii_tx_framer.sv
module tb_gmii_tx_framer;
  localparam int IFG = 12;
  localparam int PRE = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gmii_tx_framer_if u_if();

  gmii_tx_framer #(.IFG_BYTES(IFG), .PRE_BYTES(PRE)) dut (
    .i_TxClk (clk),
    .i_Reset (rst),
    .io_Gmii (u_if)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       en;
    logic       er;
    logic       busy;
  } sym_t;

  sym_t       exp_q[$];
  sym_t       mq[$];
  logic [7:0] fb[16];
  logic       fe[16];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic sym_t S(input logic [7:0] d, input logic en, input logic er, input logic busy);
    return {d, en, er, busy};
  endfunction

  // Expected line symbols for one frame, one entry per clock, from the
  // framing rules: preamble, SFD, payload (or error + discard), gap.
  // k = 1-based payload byte whose offer is withheld (0 = no underrun).
  task automatic build(input bit nib, input int n, input int k);
    int bt;
    bt = nib ? 2 : 1;
    mq.delete();
    for (int i = 0; i < bt*PRE; i++) mq.push_back(S(nib ? 8'h05 : 8'h55, 1'b1, 1'b0, 1'b1));
    if (nib) begin
      mq.push_back(S(8'h05, 1'b1, 1'b0, 1'b1));
      mq.push_back(S(8'h0D, 1'b1, 1'b0, 1'b1));
    end else begin
      mq.push_back(S(8'hD5, 1'b1, 1'b0, 1'b1));
    end
    for (int i = 0; i < n; i++) begin
      if (k != 0 && i == k-1) begin
        // remaining bytes are swallowed one per cycle, last one ends DROP
        for (int j = 0; j < n-k+1; j++) mq.push_back(S(8'h00, j < bt, j < bt, 1'b1));
        break;
      end
      if (nib) begin
        mq.push_back(S({4'h0, fb[i][3:0]}, 1'b1, fe[i], 1'b1));
        mq.push_back(S({4'h0, fb[i][7:4]}, 1'b1, fe[i], 1'b1));
      end else begin
        mq.push_back(S(fb[i], 1'b1, fe[i], 1'b1));
      end
    end
    for (int i = 0; i < bt*IFG; i++) mq.push_back(S(8'h00, 1'b0, 1'b0, 1'b1));
  endtask

  // Compare process: one expected symbol per cycle, idle when nothing queued.
  always @(posedge clk) begin
    sym_t e;
    #1;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = '0;
        check("idle_ready", u_if.o_Ready, 0);
      end
      check("txd",  u_if.o8_TxD, e.d);
      check("txen", u_if.o_TxEN, e.en);
      check("txer", u_if.o_TxER, e.er);
      check("busy", u_if.o_Busy, e.busy);
    end
  end

  task automatic clear_err();
    foreach (fe[i]) fe[i] = 1'b0;
  endtask

  // Called at a negedge. flip toggles i2_Speed every cycle after the start
  // edge; hold leaves i_Valid high for a back-to-back follower.
  task automatic send_frame(input bit nib, input int n, input int k, input bit flip, input bit hold);
    int idx, cyc;
    bit dropped, acc;
    idx = 0; cyc = 0; dropped = 1'b0;
    build(nib, n, k);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    u_if.i2_Speed = nib ? 2'b01 : 2'b10;
    while (idx < n && cyc < 3000) begin
      if (k != 0 && idx == k-1 && !dropped && u_if.o_Ready) begin
        u_if.i_Valid = 1'b0;
        dropped = 1'b1;
      end else begin
        u_if.i_Valid = 1'b1;
        u_if.i8_Data = fb[idx];
        u_if.i_Last  = (idx == n-1);
        u_if.i_Err   = fe[idx];
      end
      acc = u_if.o_Ready && u_if.i_Valid;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      cyc++;
      if (flip) u_if.i2_Speed = ~u_if.i2_Speed;
    end
    check("frame_accepted", idx, n);
    if (!hold) begin
      u_if.i_Valid = 1'b0;
      u_if.i_Last  = 1'b0;
      u_if.i_Err   = 1'b0;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int idx;
    u_if.i2_Speed = 2'b10;
    u_if.i8_Data  = 8'h00;
    u_if.i_Valid  = 1'b0;
    u_if.i_Last   = 1'b0;
    u_if.i_Err    = 1'b0;
    clear_err();

    repeat (2) @(negedge clk);
    check("rst_busy",  u_if.o_Busy, 0);
    check("rst_txen",  u_if.o_TxEN, 0);
    check("rst_ready", u_if.o_Ready, 0);
    check("rst_txd",   u_if.o8_TxD, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // pin the model against hand-derived sequences
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
    build(1'b0, 3, 0);
    check("pin_b_len",  mq.size(), 23);
    check("pin_b_sfd",  mq[7].d, 8'hD5);
    check("pin_b_d0",   mq[8].d, 8'hAA);
    check("pin_b_d2",   mq[10].d, 8'hCC);
    check("pin_b_gap",  mq[11].en, 0);
    fb[0] = 8'hA5;
    build(1'b1, 1, 0);
    check("pin_n_len",  mq.size(), 42);
    check("pin_n_pre",  mq[14].d, 8'h05);
    check("pin_n_sfd",  mq[15].d, 8'h0D);
    check("pin_n_lo",   mq[16].d, 8'h05);
    check("pin_n_hi",   mq[17].d, 8'h0A);
    check("pin_n_gap",  mq[18].en, 0);
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    build(1'b0, 4, 3);
    check("pin_u_len",  mq.size(), 24);
    check("pin_u_err",  {mq[10].d, mq[10].en, mq[10].er}, {8'h00, 1'b1, 1'b1});
    check("pin_u_off",  mq[11].en, 0);

    // byte mode AA BB CC
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; clear_err();
    send_frame(1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // nibble mode A5, speed wiggled mid-frame
    fb[0] = 8'hA5;
    send_frame(1'b1, 1, 0, 1'b1, 1'b0);
    drain();

    // byte mode underrun before byte 3
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    send_frame(1'b0, 4, 3, 1'b0, 1'b0);
    drain();

    // byte mode error on byte 2
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fe[1] = 1'b1;
    send_frame(1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // nibble mode 2 bytes, error on first, speed wiggled
    clear_err();
    fb[0] = 8'h3C; fb[1] = 8'h7E; fe[0] = 1'b1;
    send_frame(1'b1, 2, 0, 1'b1, 1'b0);
    drain();
    clear_err();

    // reset pulse during byte 5 of a 10-byte frame
    chk_en = 1'b0;
    u_if.i2_Speed = 2'b10;
    idx = 0;
    for (int c = 0; c < 100 && idx < 5; c++) begin
      bit acc;
      u_if.i_Valid = 1'b1;
      u_if.i8_Data = 8'h10 + 8'(idx);
      u_if.i_Last  = (idx == 9);
      acc = u_if.o_Ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    check("rm_byte5_d",  u_if.o8_TxD, 8'h14);
    check("rm_byte5_en", u_if.o_TxEN, 1);
    rst = 1'b1;
    #1;
    check("rm_txd",   u_if.o8_TxD, 0);
    check("rm_txen",  u_if.o_TxEN, 0);
    check("rm_txer",  u_if.o_TxER, 0);
    check("rm_busy",  u_if.o_Busy, 0);
    check("rm_ready", u_if.o_Ready, 0);
    @(negedge clk);
    rst = 1'b0;
    u_if.i_Valid = 1'b0;
    u_if.i_Last  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    fb[0] = 8'h5A; fb[1] = 8'hC3;
    send_frame(1'b0, 2, 0, 1'b0, 1'b0);
    drain();

    // back-to-back frames with i_Valid held high
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    send_frame(1'b0, 3, 0, 1'b0, 1'b1);
    fb[0] = 8'hF0; fb[1] = 8'h0F;
    send_frame(1'b0, 2, 0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
